// File: rtl/imem_loader_pkg.sv
// Shared state encoding and error codes for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        StLen,
        StData,
        StCsum,
        StDone,
        StErr
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles accepted bytes into little-endian 32-bit words; word/word_valid are presented
// combinationally in the same cycle as the 4th byte so the FSM can act on that edge.
module imem_loader_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  cnt_q;
    logic [23:0] sh_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 2'd0;
            sh_q  <= 24'd0;
        end else if (clr) begin
            cnt_q <= 2'd0;
            sh_q  <= 24'd0;
        end else if (in_valid) begin
            // Newest byte enters at the top so the first byte ends up in bits [7:0].
            sh_q  <= {in_data, sh_q[23:8]};
            cnt_q <= cnt_q + 2'd1;
        end
    end

    assign word       = {in_data, sh_q};
    assign word_valid = in_valid && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, checksummed program image into imem, holding the core in reset
// until the whole image has been written and verified.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    input  logic              start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    localparam int unsigned CntW = ADDR_W + 1;

    state_e            state_q, state_d;
    logic [CntW-1:0]   len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       sum_q, sum_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              core_rst_n_q, busy_q, done_q, error_q;

    logic              accept;
    logic              clr;
    logic [31:0]       word;
    logic              word_valid;
    logic              last_word;

    assign s_ready = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
    assign accept  = s_valid && s_ready;

    imem_loader_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .in_valid   (accept),
        .in_data    (s_data),
        .word       (word),
        .word_valid (word_valid)
    );

    // The index stops at LEN-1 instead of incrementing, so a full-depth image never wraps it.
    assign last_word = ({1'b0, idx_q} == (len_q - CntW'(1)));

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        mem_we_d    = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        err_code_d  = err_code_q;
        clr         = 1'b0;

        unique case (state_q)
            StLen: begin
                if (word_valid) begin
                    if (word > 32'(DEPTH_WORDS)) begin
                        state_d    = StErr;
                        err_code_d = ERR_LEN;
                    end else if (word == 32'd0) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                        len_d   = word[CntW-1:0];
                    end
                end
            end
            StData: begin
                if (word_valid) begin
                    mem_we_d    = 1'b1;
                    mem_waddr_d = idx_q;
                    mem_wdata_d = word;
                    sum_d       = sum_q + word;
                    if (last_word) begin
                        state_d = StCsum;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            StCsum: begin
                if (word_valid) begin
                    if (word == sum_q) begin
                        state_d = StDone;
                    end else begin
                        state_d    = StErr;
                        err_code_d = ERR_CSUM;
                    end
                end
            end
            StDone, StErr: begin
                if (start) begin
                    state_d    = StLen;
                    len_d      = '0;
                    idx_d      = '0;
                    sum_d      = '0;
                    err_code_d = ERR_NONE;
                    clr        = 1'b1;
                end
            end
            default: begin
                state_d = StLen;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StLen;
            len_q        <= '0;
            idx_q        <= '0;
            sum_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
            err_code_q   <= ERR_NONE;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            sum_q        <= sum_d;
            mem_we_q     <= mem_we_d;
            mem_waddr_q  <= mem_waddr_d;
            mem_wdata_q  <= mem_wdata_d;
            err_code_q   <= err_code_d;
            core_rst_n_q <= (state_d == StDone);
            busy_q       <= (state_d == StLen) || (state_d == StData) || (state_d == StCsum);
            done_q       <= (state_d == StDone);
            error_q      <= (state_d == StErr);
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_waddr  = mem_waddr_q;
    assign mem_wdata  = mem_wdata_q;
    assign err_code   = err_code_q;
    assign core_rst_n = core_rst_n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule
